// File: rtl/countdown_timer.sv
// Preset M:SS.d BCD countdown timer with an internal decisecond prescaler.
// Counts down while running and pulses done on reaching 0:00.0.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] set_min,
  input  logic [3:0] set_sec1,
  input  logic [3:0] set_sec0,
  input  logic [3:0] set_deci,
  output logic [3:0] min,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] deci,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [3:0]      min_q, min_d;
  logic [3:0]      sec1_q, sec1_d;
  logic [3:0]      sec0_q, sec0_d;
  logic [3:0]      deci_q, deci_d;
  logic            done_q, done_d;
  logic            nonzero;
  logic            b_deci, b_sec0, b_sec1;

  function automatic logic [3:0] clamp(input logic [3:0] v,
                                       input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign nonzero = (min_q != 4'd0) || (sec1_q != 4'd0) ||
                   (sec0_q != 4'd0) || (deci_q != 4'd0);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    min_d   = min_q;
    sec1_d  = sec1_q;
    sec0_d  = sec0_q;
    deci_d  = deci_q;
    done_d  = 1'b0;
    b_deci  = 1'b0;
    b_sec0  = 1'b0;
    b_sec1  = 1'b0;
    if (load) begin
      min_d   = clamp(set_min, 4'd9);
      sec1_d  = clamp(set_sec1, 4'd5);
      sec0_d  = clamp(set_sec0, 4'd9);
      deci_d  = clamp(set_deci, 4'd9);
      state_d = IDLE;
      pre_d   = '0;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (state_q == RUN) begin
      if (pre_q == PMAX) begin
        pre_d  = '0;
        b_deci = (deci_q == 4'd0);
        deci_d = b_deci ? 4'd9 : deci_q - 4'd1;
        if (b_deci) begin
          b_sec0 = (sec0_q == 4'd0);
          sec0_d = b_sec0 ? 4'd9 : sec0_q - 4'd1;
        end
        if (b_sec0) begin
          b_sec1 = (sec1_q == 4'd0);
          sec1_d = b_sec1 ? 4'd5 : sec1_q - 4'd1;
        end
        if (b_sec1) min_d = min_q - 4'd1;
        // reaching zero ends the run on the same edge
        if (min_d == 4'd0 && sec1_d == 4'd0 &&
            sec0_d == 4'd0 && deci_d == 4'd0) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end else if (start && nonzero &&
                 (state_q == IDLE || state_q == PAUSE)) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      pre_q   <= '0;
      min_q   <= '0;
      sec1_q  <= '0;
      sec0_q  <= '0;
      deci_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      min_q   <= min_d;
      sec1_q  <= sec1_d;
      sec0_q  <= sec0_d;
      deci_q  <= deci_d;
      done_q  <= done_d;
    end
  end

  assign min     = min_q;
  assign sec1    = sec1_q;
  assign sec0    = sec0_q;
  assign deci    = deci_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign done    = done_q;

endmodule
